ps2_rx_history: RTL
===================

// Module: ps2_rx_history
// PURPOSE
//  Parametrised PS/2 keyboard receiver for the DE-series top level.
//  - Filters the raw ps2_clk/ps2_data lines and deserialises 11-bit frames.
//  - Checks parity, stop bit and inter-edge timeout.
//  - Decodes E0/F0 prefixes into key events and keeps a HIST_DEPTH-deep history of make codes for HEX display.
//  - Receive-only: the top level owns the inout pads, with pull-ups.
// PARAMETERS
//  FILTER_LEN     8      glitch-filter length in CLOCK_50 cycles (legal range >=2)
//  HIST_DEPTH     3      number of make codes retained (legal range >=1)
//  TIMEOUT_CYC    50000  max cycles between PS/2 falling edges inside a frame (1 ms at 50 MHz; >=16)
//  DECODE_PREFIX  1      1 = interpret E0/F0 prefixes; 0 = every byte is a plain key event
// PORTS
//  CLOCK_50    in   1               system clock, 50 MHz
//  clear       in   1               synchronous active-high reset
//  ps2_clk     in   1               raw PS/2 clock line, asynchronous
//  ps2_data    in   1               raw PS/2 data line, asynchronous
//  byte_valid  out  1               1-cycle pulse: good frame received
//  byte_data   out  8               received byte; valid while byte_valid, held otherwise
//  parity_err  out  1               1-cycle pulse: odd-parity check failed
//  frame_err   out  1               1-cycle pulse: stop bit = 0, or timeout
//  key_valid   out  1               1-cycle pulse: decoded key event
//  key_code    out  8               scan code of the event
//  key_break   out  1               event is a release (F0 seen)
//  key_ext     out  1               event is extended (E0 seen)
//  hist        out  8*HIST_DEPTH    make-code history; hist[7:0] newest
//  busy        out  1               frame in progress (FSM not IDLE)
// BEHAVIOUR
//  - Reset: all outputs 0, hist all 0, FSM IDLE. Filter registers all 1 and filtered levels 1 (idle bus).
//  - clear: takes effect on the next edge from any state; partial frame, prefix flags and history are discarded.
//  - Line filter, per line:
//    - 2-FF synchroniser, then a FILTER_LEN shift register.
//    - Filtered level goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds.
//    - Latency is 2+FILTER_LEN cycles.
//  - Falling-edge detect: on the filtered clock; the filtered data is sampled in the same cycle.
//  - FSM states:
//    - IDLE: a fall with data=0 (start bit) goes to DATA with bitcnt=0. A fall with data=1 is ignored.
//    - DATA: 8 falls, LSB first, with a 3-bit bitcnt. After bitcnt==7 go to PARITY.
//    - PARITY: sample p. The frame is OK iff ^{data,p}==1 (odd parity).
//    - STOP: sample s, then go to IDLE.
//      - Good parity and s=1: byte_valid.
//      - Bad parity: parity_err.
//      - s=0: frame_err.
//      - Both faults: both flags pulse together and byte_valid stays 0.
//  - Result latency: flags and byte_valid assert in the cycle after the cycle the stop-bit fall is detected.
//  - Timeout:
//    - The counter clears on every fall and is held at 0 in IDLE.
//    - In DATA, PARITY or STOP, reaching TIMEOUT_CYC-1 without a fall gives a frame_err pulse and a return to IDLE; the partial byte is dropped.
//    - If a fall and the timeout coincide, the fall wins.
//  - Decode (DECODE_PREFIX=1), in the same cycle as byte_valid:
//    - 8'hE0 sets ext_pend; 8'hF0 sets brk_pend. Neither produces key_valid.
//    - Any other byte: key_valid=1, key_code=byte, key_break=brk_pend, key_ext=ext_pend; both pends then clear.
//    - parity_err or frame_err clears both pends.
//  - Decode (DECODE_PREFIX=0): every good byte gives key_valid with key_break=0 and key_ext=0.
//  - History:
//    - On key_valid with key_break=0, hist shifts left 8 bits and the new code enters hist[7:0].
//    - The oldest entry falls off. Break events leave hist unchanged.
//  - key_code, key_break and key_ext hold their value between events.
// STRUCTURE
//  - Package ps2_pkg:
//    - localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_FRAME_BITS=11.
//    - FSM state encoding IDLE/DATA/PARITY/STOP.
//  - Sub-module ps2_line_filter (sync + FILTER_LEN filter, parametrised): instantiated twice, once per line.
//  - Top level holds the FSM, timeout counter, decoder and history.
// TESTING
//  Bench setup: FILTER_LEN=4, TIMEOUT_CYC=200, PS/2 half-period 40 cycles, data changes mid-high.
//  1. Frame 0x1C, p=0, s=1 -> byte_valid, byte_data=1C; key_valid code=1C brk=0 ext=0; hist[7:0]=1C.
//  2. F0 then 1C -> exactly one key_valid: code=1C brk=1 ext=0; hist unchanged.
//  3. E0 then 75, then 1B -> key_valid 75 with ext=1, then 1B with ext=0; hist[15:0]=75_1B (HIST_DEPTH=3).
//  4. Frame 0x1C with p=1 -> parity_err pulse, no byte_valid; following 1C decodes as brk=0.
//  5. Stop bit 0 -> frame_err pulse. Clock stops after 4 data bits -> frame_err 200 cycles after the last fall, busy=0; next frame 0x29 decodes correctly.
//  6. 2-cycle low glitch on ps2_clk -> no bit counted. clear asserted mid-frame -> all outputs 0 next cycle; a following 0x1C is decoded.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver constants and FSM state encoding.
package ps2_pkg;
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam int PS2_FRAME_BITS = 11;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus all-ones/all-zeros glitch filter for one PS/2 line.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic level_o
);
   logic [1:0] sync_q;
   logic [FILTER_LEN-1:0] shift_q, shift_d;
   logic level_q, level_d;
   always_comb begin
      shift_d = {shift_q[FILTER_LEN-2:0], sync_q[1]};
      level_d = &shift_d ? 1'b1 : ~|shift_d ? 1'b0 : level_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '1;
         shift_q <= '1;
         level_q <= 1'b1;
      end else begin
         sync_q  <= {sync_q[0], line_i};
         shift_q <= shift_d;
         level_q <= level_d;
      end
   end
   assign level_o = level_q;
endmodule

// File: rtl/ps2_rx_history.sv
// ps2_rx_history: PS/2 frame receiver with E0/F0 prefix decode and make-code history.
module ps2_rx_history
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN    = 8,
   parameter int HIST_DEPTH    = 3,
   parameter int TIMEOUT_CYC   = 50000,
   parameter int DECODE_PREFIX = 1
) (
   input  logic                    CLOCK_50,
   input  logic                    clear,
   input  logic                    ps2_clk,
   input  logic                    ps2_data,
   output logic                    byte_valid,
   output logic [7:0]              byte_data,
   output logic                    parity_err,
   output logic                    frame_err,
   output logic                    key_valid,
   output logic [7:0]              key_code,
   output logic                    key_break,
   output logic                    key_ext,
   output logic [8*HIST_DEPTH-1:0] hist,
   output logic                    busy
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic clk_f, dat_f, clk_prev_q, fall, tmo_hit;
   ps2_state_e state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d;
   logic pok_q, pok_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic ev_good, ev_pe, ev_fe, is_ext, is_brk;
   logic ext_q, ext_d, brk_q, brk_d;
   logic bv_q, pe_q, fe_q, kv_q, kb_q, ke_q, kv_d, kb_d, ke_d;
   logic [7:0] bd_q, bd_d, kc_q, kc_d;
   logic [8*HIST_DEPTH-1:0] hist_q, hist_d;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_f (
      .clk_i(CLOCK_50), .rst_i(clear), .line_i(ps2_clk), .level_o(clk_f));
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_f (
      .clk_i(CLOCK_50), .rst_i(clear), .line_i(ps2_data), .level_o(dat_f));

   assign fall = clk_prev_q & ~clk_f;
   // A fall arriving in the same cycle as the timeout keeps the frame alive.
   assign tmo_hit = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pok_d   = pok_q;
      ev_good = 1'b0;
      ev_pe   = 1'b0;
      ev_fe   = tmo_hit;
      tmo_d   = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
      if (tmo_hit) state_d = IDLE;
      else if (fall)
         case (state_q)
            IDLE: if (!dat_f) begin
               state_d = DATA;
               bit_d   = 3'd0;
            end
            DATA: begin
               sh_d    = {dat_f, sh_q[7:1]};
               bit_d   = bit_q + 3'd1;
               state_d = (bit_q == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               pok_d   = ^{sh_q, dat_f};
               state_d = STOP;
            end
            default: begin
               state_d = IDLE;
               ev_good = pok_q & dat_f;
               ev_pe   = ~pok_q;
               ev_fe   = ~dat_f;
            end
         endcase
   end

   always_comb begin
      is_ext = (DECODE_PREFIX != 0) && (sh_q == PS2_EXT);
      is_brk = (DECODE_PREFIX != 0) && (sh_q == PS2_BRK);
      kv_d   = ev_good & ~is_ext & ~is_brk;
      bd_d   = ev_good ? sh_q : bd_q;
      kc_d   = kv_d ? sh_q : kc_q;
      kb_d   = kv_d ? brk_q : kb_q;
      ke_d   = kv_d ? ext_q : ke_q;
      ext_d  = (ev_pe | ev_fe | kv_d) ? 1'b0 : (ev_good & is_ext) ? 1'b1 : ext_q;
      brk_d  = (ev_pe | ev_fe | kv_d) ? 1'b0 : (ev_good & is_brk) ? 1'b1 : brk_q;
      hist_d = hist_q;
      if (kv_d && !brk_q) begin
         hist_d      = hist_q << 8;
         hist_d[7:0] = sh_q;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (clear) begin
         state_q    <= IDLE;
         clk_prev_q <= 1'b1;
         bit_q      <= '0;
         sh_q       <= '0;
         pok_q      <= 1'b0;
         tmo_q      <= '0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         bv_q       <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         kv_q       <= 1'b0;
         bd_q       <= '0;
         kc_q       <= '0;
         kb_q       <= 1'b0;
         ke_q       <= 1'b0;
         hist_q     <= '0;
      end else begin
         state_q    <= state_d;
         clk_prev_q <= clk_f;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         pok_q      <= pok_d;
         tmo_q      <= tmo_d;
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         bv_q       <= ev_good;
         pe_q       <= ev_pe;
         fe_q       <= ev_fe;
         kv_q       <= kv_d;
         bd_q       <= bd_d;
         kc_q       <= kc_d;
         kb_q       <= kb_d;
         ke_q       <= ke_d;
         hist_q     <= hist_d;
      end
   end

   assign byte_valid = bv_q;
   assign byte_data  = bd_q;
   assign parity_err = pe_q;
   assign frame_err  = fe_q;
   assign key_valid  = kv_q;
   assign key_code   = kc_q;
   assign key_break  = kb_q;
   assign key_ext    = ke_q;
   assign hist       = hist_q;
   assign busy       = (state_q != IDLE);
endmodule
